// File: rtl/dds_fcw_ctrl_if.sv
// Correction handshake between the Costas loop filter and the FCW sequencer.
//   corr_valid : loop filter has a correction on corr_data
//   corr_ready : sequencer accepts the correction (transfer on valid & ready)
//   corr_data  : signed two's-complement FCW correction
// master = loop filter side, slave = sequencer side.
interface dds_fcw_ctrl_if;
  logic        corr_valid;
  logic        corr_ready;
  logic [23:0] corr_data;

  modport master (
    output corr_valid,
    output corr_data,
    input  corr_ready
  );

  modport slave (
    input  corr_valid,
    input  corr_data,
    output corr_ready
  );
endinterface

// File: rtl/dds_fcw_ctrl.sv
// Frequency-control-word sequencer for the square-wave DDS of the Costas loop.
// Sweeps the FCW around CENTER_FCW until the lock detector reports a stable lock, then
// tracks using signed loop-filter corrections; drops back to sweeping on sustained loss
// of lock. freeze holds the FCW, en=0 parks the DDS in reset at the centre frequency.
// Ports:
//   clk        : system clock
//   rst        : synchronous reset, active low
//   en         : enable, 0 forces IDLE
//   corr       : correction handshake (slave side)
//   lock_ind   : lock detector output
//   freeze     : hold FCW, ignore corrections and lock loss
//   phaseincr  : FCW to the DDS (CENTER_FCW + offset)
//   dds_rst    : active-high DDS reset
//   fcw_update : one-cycle pulse in the first cycle phaseincr shows a new value
//   locked     : high in TRACK/HOLD
//   state      : 0 IDLE, 1 SWEEP, 2 TRACK, 3 HOLD
// All outputs are registered.
module dds_fcw_ctrl #(
  parameter int unsigned CENTER_FCW   = 919123001,
  parameter int unsigned SWEEP_SPAN   = 4194304,
  parameter int unsigned SWEEP_STEP   = 262144,
  parameter int unsigned DWELL_CYCLES = 4096,
  parameter int unsigned MAX_DEV      = 8388608,
  parameter int unsigned LOCK_CNT     = 64,
  parameter int unsigned UNLOCK_CNT   = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  dds_fcw_ctrl_if.slave        corr,
  input  logic                 lock_ind,
  input  logic                 freeze,
  output logic [31:0]          phaseincr,
  output logic                 dds_rst,
  output logic                 fcw_update,
  output logic                 locked,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSweep = 2'd1,
    StTrack = 2'd2,
    StHold  = 2'd3
  } state_e;

  localparam int unsigned DwellW  = $clog2(DWELL_CYCLES + 1);
  localparam int unsigned LockW   = $clog2(LOCK_CNT + 1);
  localparam int unsigned UnlockW = $clog2(UNLOCK_CNT + 1);

  localparam logic [DwellW-1:0]  DwellLast = DwellW'(DWELL_CYCLES - 1);
  localparam logic [LockW-1:0]   LockMax   = LockW'(LOCK_CNT);
  localparam logic [UnlockW-1:0] UnlockMax = UnlockW'(UNLOCK_CNT);

  localparam logic signed [33:0] SpanS      = 34'(SWEEP_SPAN);
  localparam logic signed [33:0] NegSpanS   = -SpanS;
  localparam logic signed [33:0] StepS      = 34'(SWEEP_STEP);
  localparam logic signed [33:0] MaxDevS    = 34'(MAX_DEV);
  localparam logic signed [33:0] NegMaxDevS = -MaxDevS;

  state_e                state_q, state_d;
  logic signed [33:0]    offset_q, offset_d;
  logic [DwellW-1:0]     dwell_q, dwell_d;
  logic [LockW-1:0]      lock_q, lock_d;
  logic [UnlockW-1:0]    unlock_q, unlock_d;
  logic [31:0]           phaseincr_q, phaseincr_d;
  logic                  dds_rst_q, dds_rst_d;
  logic                  fcw_update_q, fcw_update_d;
  logic                  locked_q, locked_d;
  logic                  corr_ready_q, corr_ready_d;

  logic [LockW-1:0]      lock_inc;
  logic [UnlockW-1:0]    unlock_inc;
  logic signed [33:0]    step_sum;
  logic signed [33:0]    corr_sum;
  logic                  corr_accept;

  always_comb begin
    lock_inc    = (lock_q == LockMax) ? lock_q : lock_q + 1'b1;
    unlock_inc  = (unlock_q == UnlockMax) ? unlock_q : unlock_q + 1'b1;
    step_sum    = offset_q + StepS;
    corr_sum    = offset_q + {{10{corr.corr_data[23]}}, corr.corr_data};
    corr_accept = corr.corr_valid & corr_ready_q;

    state_d  = state_q;
    offset_d = offset_q;
    dwell_d  = dwell_q;
    lock_d   = lock_q;
    unlock_d = unlock_q;

    if (!en) begin
      state_d  = StIdle;
      offset_d = '0;
      dwell_d  = '0;
      lock_d   = '0;
      unlock_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d  = StSweep;
          offset_d = NegSpanS;
          dwell_d  = '0;
          lock_d   = '0;
          unlock_d = '0;
        end
        StSweep: begin
          lock_d = lock_ind ? lock_inc : '0;
          if (lock_ind && (lock_inc == LockMax)) begin
            // Lock wins over a coincident dwell step: offset stays where lock was found.
            state_d  = StTrack;
            dwell_d  = '0;
            lock_d   = '0;
            unlock_d = '0;
          end else if (dwell_q == DwellLast) begin
            dwell_d  = '0;
            offset_d = (step_sum > SpanS) ? NegSpanS : step_sum;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
        StTrack: begin
          if (freeze) begin
            // Freeze outranks unlock; a correction taken in this last ready cycle is dropped.
            state_d = StHold;
          end else begin
            unlock_d = lock_ind ? '0 : unlock_inc;
            if (!lock_ind && (unlock_inc == UnlockMax)) begin
              state_d  = StSweep;
              offset_d = NegSpanS;
              dwell_d  = '0;
              lock_d   = '0;
              unlock_d = '0;
            end else if (corr_accept) begin
              if (corr_sum > MaxDevS) begin
                offset_d = MaxDevS;
              end else if (corr_sum < NegMaxDevS) begin
                offset_d = NegMaxDevS;
              end else begin
                offset_d = corr_sum;
              end
            end
          end
        end
        StHold: begin
          if (!freeze) begin
            state_d  = StTrack;
            unlock_d = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    phaseincr_d  = CENTER_FCW + offset_d[31:0];
    fcw_update_d = (phaseincr_d != phaseincr_q);
    dds_rst_d    = (state_d == StIdle);
    locked_d     = (state_d == StTrack) || (state_d == StHold);
    corr_ready_d = (state_d == StTrack);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      offset_q     <= '0;
      dwell_q      <= '0;
      lock_q       <= '0;
      unlock_q     <= '0;
      phaseincr_q  <= CENTER_FCW;
      dds_rst_q    <= 1'b1;
      fcw_update_q <= 1'b0;
      locked_q     <= 1'b0;
      corr_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      offset_q     <= offset_d;
      dwell_q      <= dwell_d;
      lock_q       <= lock_d;
      unlock_q     <= unlock_d;
      phaseincr_q  <= phaseincr_d;
      dds_rst_q    <= dds_rst_d;
      fcw_update_q <= fcw_update_d;
      locked_q     <= locked_d;
      corr_ready_q <= corr_ready_d;
    end
  end

  assign corr.corr_ready = corr_ready_q;
  assign phaseincr       = phaseincr_q;
  assign dds_rst         = dds_rst_q;
  assign fcw_update      = fcw_update_q;
  assign locked          = locked_q;
  assign state           = state_q;

endmodule

// File: tb/tb_dds_fcw_ctrl.sv
// Bench for dds_fcw_ctrl: directed scenarios followed by random stimulus, every cycle
// compared against a cycle-level behavioural model of the sequencer.
module tb_dds_fcw_ctrl;
  localparam int CENTER  = 1000;
  localparam int SPAN    = 40;
  localparam int STEP    = 20;
  localparam int DWELL   = 4;
  localparam int MAXDEV  = 100;
  localparam int LOCKN   = 3;
  localparam int UNLOCKN = 5;

  logic        clk = 1'b0;
  logic        rst, en, lock_ind, freeze;
  logic [31:0] phaseincr;
  logic        dds_rst, fcw_update, locked;
  logic [1:0]  state;

  dds_fcw_ctrl_if corr_if ();

  dds_fcw_ctrl #(
    .CENTER_FCW   (CENTER),
    .SWEEP_SPAN   (SPAN),
    .SWEEP_STEP   (STEP),
    .DWELL_CYCLES (DWELL),
    .MAX_DEV      (MAXDEV),
    .LOCK_CNT     (LOCKN),
    .UNLOCK_CNT   (UNLOCKN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .corr       (corr_if),
    .lock_ind   (lock_ind),
    .freeze     (freeze),
    .phaseincr  (phaseincr),
    .dds_rst    (dds_rst),
    .fcw_update (fcw_update),
    .locked     (locked),
    .state      (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: mode 0 IDLE, 1 SWEEP, 2 TRACK, 3 HOLD; counters count elapsed cycles.
  int          m_mode = 0;
  int          m_off = 0;
  int          m_elapsed = 0;
  int          m_ones = 0;
  int          m_zeros = 0;
  logic [31:0] m_pi = 32'(CENTER);
  logic        m_upd = 1'b0;
  logic        m_ready = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_step();
    logic [31:0] prev_pi;
    logic        took;
    int          s;
    prev_pi = m_pi;
    took    = corr_if.corr_valid && m_ready;
    if (!rst) begin
      m_mode = 0; m_off = 0; m_elapsed = 0; m_ones = 0; m_zeros = 0;
      m_pi = 32'(CENTER); m_upd = 1'b0; m_ready = 1'b0;
      return;
    end
    if (!en) begin
      m_mode = 0; m_off = 0; m_elapsed = 0; m_ones = 0; m_zeros = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_off = -SPAN; m_elapsed = 0; m_ones = 0; m_zeros = 0;
    end else if (m_mode == 1) begin
      m_ones = lock_ind ? m_ones + 1 : 0;
      if (m_ones >= LOCKN) begin
        m_mode = 2; m_ones = 0; m_elapsed = 0; m_zeros = 0;
      end else begin
        m_elapsed++;
        if (m_elapsed == DWELL) begin
          m_elapsed = 0;
          m_off += STEP;
          if (m_off > SPAN) m_off = -SPAN;
        end
      end
    end else if (m_mode == 2) begin
      if (freeze) begin
        m_mode = 3;
      end else begin
        m_zeros = lock_ind ? 0 : m_zeros + 1;
        if (m_zeros >= UNLOCKN) begin
          m_mode = 1; m_off = -SPAN; m_elapsed = 0; m_ones = 0; m_zeros = 0;
        end else if (took) begin
          s = m_off + int'($signed(corr_if.corr_data));
          m_off = (s > MAXDEV) ? MAXDEV : (s < -MAXDEV) ? -MAXDEV : s;
        end
      end
    end else begin
      if (!freeze) begin
        m_mode = 2; m_zeros = 0;
      end
    end
    m_pi    = 32'(CENTER + m_off);
    m_upd   = (m_pi != prev_pi);
    m_ready = (m_mode == 2);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_eq("m_phaseincr", phaseincr, m_pi);
    check_eq("m_fcw_update", 32'(fcw_update), 32'(m_upd));
    check_eq("m_dds_rst", 32'(dds_rst), 32'(m_mode == 0));
    check_eq("m_locked", 32'(locked), 32'(m_mode >= 2));
    check_eq("m_state", 32'(state), 32'(m_mode));
    check_eq("m_corr_ready", 32'(corr_if.corr_ready), 32'(m_ready));
  endtask

  int   sweep_exp[6] = '{960, 980, 1000, 1020, 1040, 960};
  bit   lock_pat[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  int   track_exp[5] = '{1030, 1060, 1090, 1100, 900};
  int   lock_mode;

  initial begin
    rst = 1'b0; en = 1'b0; lock_ind = 1'b0; freeze = 1'b0;
    corr_if.corr_valid = 1'b0; corr_if.corr_data = '0;

    // Reset and enable
    repeat (5) tick();
    check_eq("rst_pi", phaseincr, 32'd1000);
    check_eq("rst_dds", 32'(dds_rst), 32'd1);
    check_eq("rst_state", 32'(state), 32'd0);
    rst = 1'b1; en = 1'b1;
    tick();
    check_eq("en_state", 32'(state), 32'd1);
    check_eq("en_dds", 32'(dds_rst), 32'd0);

    // Sweep sequence with wrap
    for (int k = 0; k < 6; k++) begin
      for (int j = 0; j < 4; j++) begin
        check_eq("sweep_pi", phaseincr, 32'(sweep_exp[k]));
        check_eq("sweep_upd", 32'(fcw_update), 32'(j == 0));
        tick();
      end
    end

    // Acquire: broken run of ones must restart the count
    tick();
    for (int i = 0; i < 6; i++) begin
      lock_ind = lock_pat[i];
      tick();
      check_eq("acq_state", 32'(state), (i == 5) ? 32'd2 : 32'd1);
    end
    check_eq("acq_pi", phaseincr, 32'd1000);
    check_eq("acq_locked", 32'(locked), 32'd1);

    // Track with clamping
    corr_if.corr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      corr_if.corr_data = (i == 4) ? 24'hffff06 : 24'd30;
      tick();
      check_eq("track_pi", phaseincr, 32'(track_exp[i]));
    end
    corr_if.corr_valid = 1'b0;
    freeze = 1'b1;
    tick();
    check_eq("frz_ready", 32'(corr_if.corr_ready), 32'd0);
    corr_if.corr_valid = 1'b1; corr_if.corr_data = 24'd30;
    tick();
    check_eq("frz_pi", phaseincr, 32'd900);

    // Unlock: ignored in HOLD, effective in TRACK
    corr_if.corr_valid = 1'b0; lock_ind = 1'b0;
    repeat (10) tick();
    check_eq("hold_state", 32'(state), 32'd3);
    freeze = 1'b0;
    tick();
    check_eq("unfrz_state", 32'(state), 32'd2);
    repeat (4) tick();
    check_eq("unl4_state", 32'(state), 32'd2);
    corr_if.corr_valid = 1'b1;
    tick();
    check_eq("unl_state", 32'(state), 32'd1);
    check_eq("unl_pi", phaseincr, 32'd960);
    corr_if.corr_valid = 1'b0;

    // Disable mid-TRACK, then reset during SWEEP
    lock_ind = 1'b1;
    repeat (3) tick();
    check_eq("relock_state", 32'(state), 32'd2);
    en = 1'b0;
    tick();
    check_eq("dis_state", 32'(state), 32'd0);
    check_eq("dis_pi", phaseincr, 32'd1000);
    check_eq("dis_dds", 32'(dds_rst), 32'd1);
    en = 1'b1; lock_ind = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_eq("srst_pi", phaseincr, 32'd1000);
    check_eq("srst_upd", 32'(fcw_update), 32'd0);
    check_eq("srst_state", 32'(state), 32'd0);
    rst = 1'b1;

    // Random stimulus against the model
    lock_mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 25 == 0) lock_mode = $urandom_range(0, 2);
      case (lock_mode)
        0:       lock_ind = ($urandom_range(0, 15) == 0);
        1:       lock_ind = ($urandom_range(0, 15) != 0);
        default: lock_ind = 1'($urandom_range(0, 1));
      endcase
      en  = ($urandom_range(0, 99) != 0);
      rst = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 29) == 0) freeze = ~freeze;
      corr_if.corr_valid = 1'($urandom_range(0, 1));
      corr_if.corr_data  = 24'($urandom_range(0, 300)) - 24'd150;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
